// File: rtl/ex_pkg.sv
// Shared types and constants for the RV64 execute stage.
// Covers ALU op decode, forwarding selects, squash FSM states and branch funct3 codes.
package ex_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } ex_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Branches reuse the subtractor; I-type never subtracts, bit 30 only picks srai.
    function automatic alu_op_e alu_decode(input aluop_e op, input logic [2:0] f3, input logic f7b5);
        alu_op_e sel;
        sel = ALU_ADD;
        case (op)
            ALUOP_ADD:    sel = ALU_ADD;
            ALUOP_BRANCH: sel = ALU_SUB;
            default: begin
                case (f3)
                    3'b000: sel = (op == ALUOP_RTYPE && f7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: sel = ALU_SLL;
                    3'b010: sel = ALU_SLT;
                    3'b011: sel = ALU_SLTU;
                    3'b100: sel = ALU_XOR;
                    3'b101: sel = f7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: sel = ALU_OR;
                    3'b111: sel = ALU_AND;
                    default: sel = ALU_ADD;
                endcase
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ex_stage_unit_forward.sv
// Operand forwarding select for the execute stage (EX/MEM over MEM/WB over ID/EX).
// Enabled by EX_FORWARD_EN; without it the ID/EX operands pass straight through.
module ex_forward_unit
    import ex_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   rdata1,
    input  logic [XLEN-1:0]   rdata2,
    input  logic [REG_AW-1:0] rd_exmem,
    input  logic              reg_write_exmem,
    input  logic              mem_read_exmem,
    input  logic [XLEN-1:0]   alu_result_exmem,
    input  logic [REG_AW-1:0] rd_memwb,
    input  logic              reg_write_memwb,
    input  logic [XLEN-1:0]   wb_data_memwb,
    output logic [XLEN-1:0]   fwd_a,
    output logic [XLEN-1:0]   fwd_b
);

`ifdef EX_FORWARD_EN
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    // A load's EX/MEM result is an address, not data, so it is never forwarded.
    always_comb begin
        sel_a = FWD_REG;
        sel_b = FWD_REG;
        if (reg_write_exmem && !mem_read_exmem && rd_exmem != '0 && rd_exmem == rs1)
            sel_a = FWD_EXMEM;
        else if (reg_write_memwb && rd_memwb != '0 && rd_memwb == rs1)
            sel_a = FWD_MEMWB;
        if (reg_write_exmem && !mem_read_exmem && rd_exmem != '0 && rd_exmem == rs2)
            sel_b = FWD_EXMEM;
        else if (reg_write_memwb && rd_memwb != '0 && rd_memwb == rs2)
            sel_b = FWD_MEMWB;

        case (sel_a)
            FWD_EXMEM: fwd_a = alu_result_exmem;
            FWD_MEMWB: fwd_a = wb_data_memwb;
            default:   fwd_a = rdata1;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_b = alu_result_exmem;
            FWD_MEMWB: fwd_b = wb_data_memwb;
            default:   fwd_b = rdata2;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs1, rs2, rd_exmem, reg_write_exmem, mem_read_exmem,
                          alu_result_exmem, rd_memwb, reg_write_memwb, wb_data_memwb};
    assign fwd_a = rdata1;
    assign fwd_b = rdata2;
`endif

endmodule

// File: rtl/ex_stage_unit.sv
// RV64 execute stage: forwarding, ALU, branch resolve/redirect, EX/MEM register, squash FSM.
// Optional operand forwarding is controlled by the EX_FORWARD_EN macro.
module ex_stage_unit
    import ex_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              holdEX,
    input  logic [XLEN-1:0]   pcIDEX,
    input  logic [XLEN-1:0]   read_data1IDEX,
    input  logic [XLEN-1:0]   read_data2IDEX,
    input  logic [XLEN-1:0]   immeIDEX,
    input  logic [REG_AW-1:0] rs1IDEX,
    input  logic [REG_AW-1:0] rs2IDEX,
    input  logic [REG_AW-1:0] rdIDEX,
    input  logic [2:0]        funct3IDEX,
    input  logic              funct7b5IDEX,
    input  logic              MemtoRegIDEX,
    input  logic              RegWriteIDEX,
    input  logic              BranchIDEX,
    input  logic              MemWriteIDEX,
    input  logic              MemReadIDEX,
    input  logic              ALUSrcIDEX,
    input  logic [1:0]        ALUOpIDEX,
    input  logic [REG_AW-1:0] rdMEMWB,
    input  logic              RegWriteMEMWB,
    input  logic [XLEN-1:0]   wbDataMEMWB,
    output logic [XLEN-1:0]   aluResultEXMEM,
    output logic [XLEN-1:0]   writeDataEXMEM,
    output logic [REG_AW-1:0] rdEXMEM,
    output logic [2:0]        funct3EXMEM,
    output logic              MemtoRegEXMEM,
    output logic              RegWriteEXMEM,
    output logic              MemWriteEXMEM,
    output logic              MemReadEXMEM,
    output logic              pcSrc,
    output logic [XLEN-1:0]   branchTarget,
    output logic              flushIFID
);

    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_y;
    logic [5:0]        shamt;
    alu_op_e           alu_op;
    logic              cond;
    logic              taken;
    logic              squash;

    ex_state_e         state_q, state_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;

    ex_forward_unit #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fwd (
        .rs1              (rs1IDEX),
        .rs2              (rs2IDEX),
        .rdata1           (read_data1IDEX),
        .rdata2           (read_data2IDEX),
        .rd_exmem         (rd_q),
        .reg_write_exmem  (reg_write_q),
        .mem_read_exmem   (mem_read_q),
        .alu_result_exmem (alu_result_q),
        .rd_memwb         (rdMEMWB),
        .reg_write_memwb  (RegWriteMEMWB),
        .wb_data_memwb    (wbDataMEMWB),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b)
    );

    always_comb begin
        op_b   = ALUSrcIDEX ? immeIDEX : fwd_b;
        shamt  = op_b[5:0];
        alu_op = alu_decode(aluop_e'(ALUOpIDEX), funct3IDEX, funct7b5IDEX);
        alu_y  = '0;
        case (alu_op)
            ALU_ADD:  alu_y = fwd_a + op_b;
            ALU_SUB:  alu_y = fwd_a - op_b;
            ALU_SLL:  alu_y = fwd_a << shamt;
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
            ALU_XOR:  alu_y = fwd_a ^ op_b;
            ALU_SRL:  alu_y = fwd_a >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(fwd_a) >>> shamt);
            ALU_OR:   alu_y = fwd_a | op_b;
            ALU_AND:  alu_y = fwd_a & op_b;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3IDEX)
            F3_BEQ:  cond = (fwd_a == fwd_b);
            F3_BNE:  cond = (fwd_a != fwd_b);
            F3_BLT:  cond = ($signed(fwd_a) < $signed(fwd_b));
            F3_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: cond = (fwd_a < fwd_b);
            F3_BGEU: cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    // The wrong-path slot after a redirect is squashed here, so ID/EX needs no flush.
    assign squash       = (state_q == SQUASH);
    assign taken        = BranchIDEX && cond && !squash && !holdEX && !RST;
    assign pcSrc        = taken;
    assign flushIFID    = taken;
    assign branchTarget = pcIDEX + immeIDEX;

    always_comb begin
        state_d = state_q;
        if (!holdEX) begin
            case (state_q)
                IDLE:    if (taken) state_d = SQUASH;
                SQUASH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
        funct3_d     = funct3_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_read_d   = mem_read_q;
        if (!holdEX) begin
            alu_result_d = alu_y;
            write_data_d = fwd_b;
            rd_d         = rdIDEX;
            funct3_d     = funct3IDEX;
            mem_to_reg_d = MemtoRegIDEX && !squash;
            reg_write_d  = RegWriteIDEX && !squash;
            mem_write_d  = MemWriteIDEX && !squash;
            mem_read_d   = MemReadIDEX  && !squash;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
        end
    end

    assign aluResultEXMEM = alu_result_q;
    assign writeDataEXMEM = write_data_q;
    assign rdEXMEM        = rd_q;
    assign funct3EXMEM    = funct3_q;
    assign MemtoRegEXMEM  = mem_to_reg_q;
    assign RegWriteEXMEM  = reg_write_q;
    assign MemWriteEXMEM  = mem_write_q;
    assign MemReadEXMEM   = mem_read_q;

endmodule
